// File: rtl/vga_pkg.sv
// Shared definitions for the VGA timing receive path: FSM encoding,
// nominal frame geometry and counter widths derived from it.
package vga_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } sync_state_e;

  localparam int H_TOTAL = 768;
  localparam int V_TOTAL = 512;

  // One extra bit of headroom so a stalled or overlong source saturates
  // well beyond any legal period instead of aliasing.
  localparam int HCNT_W = $clog2(H_TOTAL) + 1;
  localparam int LCNT_W = $clog2(V_TOTAL) + 1;

  function automatic logic [HCNT_W-1:0] abs_diff(input logic [HCNT_W-1:0] a,
                                                 input logic [HCNT_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Registers one input bit and keeps its previous value, giving the
// registered level plus single-cycle rise and fall pulses.
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic cur_q, cur_d;
  logic prev_q, prev_d;

  always_comb begin
    cur_d  = d;
    prev_d = cur_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_q  <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      cur_q  <= cur_d;
      prev_q <= prev_d;
    end
  end

  assign level = cur_q;
  assign rise  = cur_q & ~prev_q;
  assign fall  = ~cur_q & prev_q;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers VGA timing from active-low syncs and display enable: pixel
// coordinates, measured line/frame geometry, lock state and error pulses.
module vga_sync_decoder
  import vga_pkg::*;
#(
  parameter int LOCK_FRAMES = 2,
  parameter int LOSS_LINES  = 4,
  parameter int H_TOL       = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vga_h_sync,
  input  logic        vga_v_sync,
  input  logic        inDisplayArea,
  output logic [9:0]  pixel_x,
  output logic [8:0]  pixel_y,
  output logic        pixel_valid,
  output logic [10:0] line_len,
  output logic [9:0]  frame_lines,
  output logic        frame_start,
  output logic        locked,
  output logic        timing_error
);

  localparam logic [HCNT_W-1:0] HCNT_MAX  = '1;
  localparam logic [LCNT_W-1:0] LCNT_MAX  = '1;
  localparam logic [HCNT_W-1:0] H_TOL_C   = HCNT_W'(H_TOL);
  localparam logic [2:0]        LOCK_C    = 3'(LOCK_FRAMES);
  localparam logic [3:0]        LOSS_C    = 4'(LOSS_LINES);

  logic h_level, h_rise, h_lead;
  logic v_level, v_rise, v_lead;
  logic de_lvl, de_rise, de_fall;

  edge_detect u_h_edge (.clk(clk), .reset(reset), .d(vga_h_sync),
                        .level(h_level), .rise(h_rise), .fall(h_lead));
  edge_detect u_v_edge (.clk(clk), .reset(reset), .d(vga_v_sync),
                        .level(v_level), .rise(v_rise), .fall(v_lead));
  edge_detect u_de_edge (.clk(clk), .reset(reset), .d(inDisplayArea),
                         .level(de_lvl), .rise(de_rise), .fall(de_fall));

  logic unused_sync;
  assign unused_sync = h_level ^ v_level ^ h_rise ^ v_rise;

  sync_state_e        state_q, state_d;
  logic [HCNT_W-1:0]  hcnt_q, hcnt_d;
  logic [LCNT_W-1:0]  lcnt_q, lcnt_d;
  logic [2:0]         match_q, match_d;
  logic [3:0]         miss_q, miss_d;
  logic               have_line_q, have_line_d;
  logic [9:0]         pixel_x_q, pixel_x_d;
  logic [8:0]         pixel_y_q, pixel_y_d;
  logic               pixel_valid_q, pixel_valid_d;
  logic [10:0]        line_len_q, line_len_d;
  logic [9:0]         frame_lines_q, frame_lines_d;
  logic               frame_start_q, frame_start_d;
  logic               locked_q, locked_d;
  logic               timing_error_q, timing_error_d;

  logic [LCNT_W-1:0]  lcnt_now;
  logic               h_sat, l_sat, line_ok;

  always_comb begin
    state_d        = state_q;
    match_d        = match_q;
    miss_d         = miss_q;
    have_line_d    = have_line_q;
    pixel_x_d      = pixel_x_q;
    pixel_y_d      = pixel_y_q;
    pixel_valid_d  = pixel_valid_q;
    line_len_d     = line_len_q;
    frame_lines_d  = frame_lines_q;
    frame_start_d  = v_lead;
    locked_d       = locked_q;
    timing_error_d = 1'b0;

    // The h edge is counted before any v edge in the same cycle, so a
    // coincident v edge sees the line that just started.
    lcnt_now = lcnt_q;
    l_sat    = 1'b0;
    if (h_lead && (lcnt_q != LCNT_MAX)) begin
      lcnt_now = lcnt_q + 1'b1;
      l_sat    = (lcnt_now == LCNT_MAX);
    end
    lcnt_d = v_lead ? '0 : lcnt_now;

    h_sat = 1'b0;
    if (h_lead) begin
      hcnt_d = HCNT_W'(1);
    end else if (hcnt_q != HCNT_MAX) begin
      hcnt_d = hcnt_q + 1'b1;
      h_sat  = (hcnt_d == HCNT_MAX);
    end else begin
      hcnt_d = hcnt_q;
    end

    line_ok = (abs_diff(hcnt_q, line_len_q) <= H_TOL_C);

    if (de_rise) begin
      pixel_x_d     = '0;
      pixel_valid_d = 1'b1;
    end else if (de_fall) begin
      pixel_valid_d = 1'b0;
      pixel_y_d     = pixel_y_q + 1'b1;
    end else if (pixel_valid_q && de_lvl && (pixel_x_q != 10'h3FF)) begin
      pixel_x_d = pixel_x_q + 1'b1;
    end
    if (v_lead) pixel_y_d = '0;

    unique case (state_q)
      ST_SEARCH: begin
        if (v_lead) begin
          state_d     = ST_MEASURE;
          match_d     = '0;
          have_line_d = 1'b0;
        end
      end
      ST_MEASURE: begin
        if (h_lead) begin
          if (!have_line_q) begin
            line_len_d  = hcnt_q;
            have_line_d = 1'b1;
          end else if (!line_ok) begin
            line_len_d = hcnt_q;
            match_d    = '0;
          end
        end
        // match_d is the length of the current run of identical frames.
        if (v_lead) begin
          if (lcnt_now == frame_lines_q) begin
            match_d = match_d + 1'b1;
          end else begin
            frame_lines_d = lcnt_now;
            match_d       = 3'd1;
          end
          if (match_d == LOCK_C) begin
            state_d  = ST_LOCKED;
            locked_d = 1'b1;
            miss_d   = '0;
          end
        end
      end
      ST_LOCKED: begin
        if (h_lead) begin
          if (!line_ok) begin
            timing_error_d = 1'b1;
            miss_d         = miss_q + 1'b1;
            if (miss_q == LOSS_C - 4'd1) begin
              state_d  = ST_SEARCH;
              locked_d = 1'b0;
            end
          end else begin
            miss_d = '0;
          end
        end
        if (v_lead && (lcnt_now != frame_lines_q)) begin
          timing_error_d = 1'b1;
          state_d        = ST_SEARCH;
          locked_d       = 1'b0;
        end
      end
      default: state_d = ST_SEARCH;
    endcase

    if (h_sat || l_sat) begin
      timing_error_d = 1'b1;
      state_d        = ST_SEARCH;
      locked_d       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_SEARCH;
      hcnt_q         <= '0;
      lcnt_q         <= '0;
      match_q        <= '0;
      miss_q         <= '0;
      have_line_q    <= 1'b0;
      pixel_x_q      <= '0;
      pixel_y_q      <= '0;
      pixel_valid_q  <= 1'b0;
      line_len_q     <= '0;
      frame_lines_q  <= '0;
      frame_start_q  <= 1'b0;
      locked_q       <= 1'b0;
      timing_error_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      hcnt_q         <= hcnt_d;
      lcnt_q         <= lcnt_d;
      match_q        <= match_d;
      miss_q         <= miss_d;
      have_line_q    <= have_line_d;
      pixel_x_q      <= pixel_x_d;
      pixel_y_q      <= pixel_y_d;
      pixel_valid_q  <= pixel_valid_d;
      line_len_q     <= line_len_d;
      frame_lines_q  <= frame_lines_d;
      frame_start_q  <= frame_start_d;
      locked_q       <= locked_d;
      timing_error_q <= timing_error_d;
    end
  end

  assign pixel_x      = pixel_x_q;
  assign pixel_y      = pixel_y_q;
  assign pixel_valid  = pixel_valid_q;
  assign line_len     = line_len_q;
  assign frame_lines  = frame_lines_q;
  assign frame_start  = frame_start_q;
  assign locked       = locked_q;
  assign timing_error = timing_error_q;

endmodule
